n101_icb_ram_pipe: RTL and testbench



---
 rtl/n101_mem_pkg.sv | 17 +
 rtl/n101_gnrl_ram.sv | 32 +++
 rtl/n101_icb_rsp_fifo.sv | 57 +++++
 rtl/n101_icb_ram_pipe.sv | 135 +++++++++++++
 tb/tb_n101_icb_ram_pipe.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/n101_mem_pkg.sv
// Shared definitions for the n101 ICB memory blocks: address alignment helper,
// legal read latencies and the response tag carried alongside RAM reads.
package n101_mem_pkg;

    localparam int RAM_LAT_RAW = 1;
    localparam int RAM_LAT_REG = 2;

    typedef struct packed {
        logic read;
        logic err;
    } rsp_tag_t;

    function automatic int aw_lsb(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/n101_gnrl_ram.sv
// Generic single-port synchronous RAM with byte write enables and registered read data.
module n101_gnrl_ram #(
    parameter int DP = 1024,
    parameter int DW = 32,
    parameter int MW = 4,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          cs,
    input  logic          we,
    input  logic [MW-1:0] wem,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [DP];

    always_ff @(posedge clk) begin
        if (cs & we) begin
            for (int i = 0; i < MW; i++) begin
                if (wem[i]) begin
                    mem[addr][i*8 +: 8] <= din[i*8 +: 8];
                end
            end
        end
        if (cs & ~we) begin
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/n101_icb_rsp_fifo.sv
// In-order response FIFO; an empty FIFO passes the incoming entry straight through.
module n101_icb_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             empty;
    logic             push;
    logic             pop;

    assign empty   = (count == '0);
    // An entry consumed in its arrival cycle never needs a slot.
    assign push    = wr_vld & ~(empty & rd_ready);
    assign pop     = ~empty & rd_ready;
    assign rd_data = empty ? wr_data : mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + PW'(1);
            end
            if (pop) begin
                rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + PW'(1);
            end
            if (push & ~pop) begin
                count <= count + CW'(1);
            end else if (pop & ~push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/n101_icb_ram_pipe.sv
// ICB-slave SRAM with configurable read latency, several outstanding commands and an
// in-order response buffer; addresses beyond the populated size return an error response.
module n101_icb_ram_pipe
    import n101_mem_pkg::*;
#(
    parameter int AW         = 12,
    parameter int DW         = 32,
    parameter int SIZE_BYTES = 4096,
    parameter int RAM_LAT    = 1,
    parameter int OUTS       = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            icb_cmd_valid,
    output logic            icb_cmd_ready,
    input  logic            icb_cmd_read,
    input  logic [AW-1:0]   icb_cmd_addr,
    input  logic [DW-1:0]   icb_cmd_wdata,
    input  logic [DW/8-1:0] icb_cmd_wmask,
    output logic            icb_rsp_valid,
    input  logic            icb_rsp_ready,
    output logic [DW-1:0]   icb_rsp_rdata,
    output logic            icb_rsp_err
);

    localparam int LSB = aw_lsb(DW);
    localparam int DP  = SIZE_BYTES / (DW / 8);
    localparam int RAW = AW - LSB;
    localparam int CW  = $clog2(OUTS + 1);

    logic [CW-1:0] cnt;
    logic          cmd_hsk;
    logic          rsp_hsk;
    logic          in_range;
    logic          ram_cs;
    logic          ram_we;
    logic [DW-1:0] ram_dout;

    assign icb_cmd_ready = (cnt < CW'(OUTS));
    assign cmd_hsk       = icb_cmd_valid & icb_cmd_ready;
    assign rsp_hsk       = icb_rsp_valid & icb_rsp_ready;
    assign in_range      = ((AW+1)'(icb_cmd_addr) < (AW+1)'(SIZE_BYTES));
    assign ram_cs        = cmd_hsk & in_range;
    assign ram_we        = ~icb_cmd_read & (|icb_cmd_wmask);

    // Credits bound the commands in flight so the response FIFO can never overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cmd_hsk & ~rsp_hsk) begin
            cnt <= cnt + CW'(1);
        end else if (~cmd_hsk & rsp_hsk) begin
            cnt <= cnt - CW'(1);
        end
    end

    n101_gnrl_ram #(
        .DP (DP),
        .DW (DW),
        .MW (DW / 8),
        .AW (RAW)
    ) u_ram (
        .clk  (clk),
        .cs   (ram_cs),
        .we   (ram_we),
        .wem  (icb_cmd_wmask),
        .addr (icb_cmd_addr[AW-1:LSB]),
        .din  (icb_cmd_wdata),
        .dout (ram_dout)
    );

    rsp_tag_t      s1_tag;
    logic          s1_vld;
    rsp_tag_t      out_tag;
    logic          out_vld;
    logic [DW-1:0] out_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_tag <= '0;
        end else begin
            s1_vld <= cmd_hsk;
            s1_tag <= cmd_hsk ? rsp_tag_t'{read: icb_cmd_read, err: ~in_range} : rsp_tag_t'('0);
        end
    end

    generate
        if (RAM_LAT == RAM_LAT_REG) begin : g_lat2
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_vld  <= 1'b0;
                    out_tag  <= '0;
                    out_dout <= '0;
                end else begin
                    out_vld <= s1_vld;
                    out_tag <= s1_tag;
                    if (s1_vld & s1_tag.read & ~s1_tag.err) begin
                        out_dout <= ram_dout;
                    end
                end
            end
        end else begin : g_lat1
            assign out_vld  = s1_vld;
            assign out_tag  = s1_tag;
            assign out_dout = ram_dout;
        end
    endgenerate

    logic [DW:0]   pipe_data;
    logic [DW:0]   head_data;
    logic [CW-1:0] fifo_cnt;

    assign pipe_data[DW]     = out_vld & out_tag.err;
    assign pipe_data[DW-1:0] = (out_vld & out_tag.read & ~out_tag.err) ? out_dout : '0;

    n101_icb_rsp_fifo #(
        .DEPTH (OUTS),
        .WIDTH (DW + 1),
        .CW    (CW)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_vld   (out_vld),
        .wr_data  (pipe_data),
        .rd_ready (icb_rsp_ready),
        .rd_data  (head_data),
        .count    (fifo_cnt)
    );

    assign icb_rsp_valid = (fifo_cnt != '0) | out_vld;
    assign icb_rsp_rdata = head_data[DW-1:0];
    assign icb_rsp_err   = head_data[DW];

endmodule

// File: tb/tb_n101_icb_ram_pipe.sv
// Directed bench for n101_icb_ram_pipe: a 32-bit single-latency instance with a
// 3 KiB populated range and a 64-bit two-latency instance used for back-pressure.
module tb_n101_icb_ram_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_cmd_valid, a_cmd_ready, a_cmd_read;
    logic [11:0] a_cmd_addr;
    logic [31:0] a_cmd_wdata;
    logic [3:0]  a_cmd_wmask;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_rsp_rdata;

    logic        b_cmd_valid, b_cmd_ready, b_cmd_read;
    logic [11:0] b_cmd_addr;
    logic [63:0] b_cmd_wdata;
    logic [7:0]  b_cmd_wmask;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [63:0] b_rsp_rdata;

    n101_icb_ram_pipe #(
        .AW(12), .DW(32), .SIZE_BYTES(3072), .RAM_LAT(1), .OUTS(2)
    ) u_dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (a_cmd_valid),
        .icb_cmd_ready (a_cmd_ready),
        .icb_cmd_read  (a_cmd_read),
        .icb_cmd_addr  (a_cmd_addr),
        .icb_cmd_wdata (a_cmd_wdata),
        .icb_cmd_wmask (a_cmd_wmask),
        .icb_rsp_valid (a_rsp_valid),
        .icb_rsp_ready (a_rsp_ready),
        .icb_rsp_rdata (a_rsp_rdata),
        .icb_rsp_err   (a_rsp_err)
    );

    n101_icb_ram_pipe #(
        .AW(12), .DW(64), .SIZE_BYTES(4096), .RAM_LAT(2), .OUTS(2)
    ) u_dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (b_cmd_valid),
        .icb_cmd_ready (b_cmd_ready),
        .icb_cmd_read  (b_cmd_read),
        .icb_cmd_addr  (b_cmd_addr),
        .icb_cmd_wdata (b_cmd_wdata),
        .icb_cmd_wmask (b_cmd_wmask),
        .icb_rsp_valid (b_rsp_valid),
        .icb_rsp_ready (b_rsp_ready),
        .icb_rsp_rdata (b_rsp_rdata),
        .icb_rsp_err   (b_rsp_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one command cycle on instance A and check the response presented in it.
    task automatic a_cycle(input string tag, input logic v, input logic rd,
                           input logic [11:0] ad, input logic [31:0] wd, input logic [3:0] wm,
                           input logic erv, input logic [31:0] erd, input logic eer);
        a_cmd_valid = v;
        a_cmd_read  = rd;
        a_cmd_addr  = ad;
        a_cmd_wdata = wd;
        a_cmd_wmask = wm;
        @(negedge clk);
        chk({tag, ".cmd_ready"}, 64'(a_cmd_ready), 64'd1);
        chk({tag, ".rsp_valid"}, 64'(a_rsp_valid), 64'(erv));
        if (erv) begin
            chk({tag, ".rdata"}, 64'(a_rsp_rdata), 64'(erd));
            chk({tag, ".err"}, 64'(a_rsp_err), 64'(eer));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic b_cycle(input string tag, input logic v, input logic rd,
                           input logic [11:0] ad, input logic [63:0] wd, input logic [7:0] wm,
                           input logic rr, input logic ecr, input logic erv,
                           input logic [63:0] erd);
        b_cmd_valid = v;
        b_cmd_read  = rd;
        b_cmd_addr  = ad;
        b_cmd_wdata = wd;
        b_cmd_wmask = wm;
        b_rsp_ready = rr;
        @(negedge clk);
        chk({tag, ".cmd_ready"}, 64'(b_cmd_ready), 64'(ecr));
        chk({tag, ".rsp_valid"}, 64'(b_rsp_valid), 64'(erv));
        if (erv) begin
            chk({tag, ".rdata"}, b_rsp_rdata, erd);
            chk({tag, ".err"}, 64'(b_rsp_err), 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] DA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] DB = 64'hBBBB_BBBB_BBBB_BBBB;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        a_cmd_valid = 0; a_cmd_read = 0; a_cmd_addr = '0; a_cmd_wdata = '0; a_cmd_wmask = '0;
        a_rsp_ready = 1;
        b_cmd_valid = 0; b_cmd_read = 0; b_cmd_addr = '0; b_cmd_wdata = '0; b_cmd_wmask = '0;
        b_rsp_ready = 1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.a.cmd_ready", 64'(a_cmd_ready), 64'd1);
        chk("rst.a.rsp_valid", 64'(a_rsp_valid), 64'd0);
        chk("rst.a.rdata",     64'(a_rsp_rdata), 64'd0);
        chk("rst.a.err",       64'(a_rsp_err),   64'd0);
        chk("rst.b.cmd_ready", 64'(b_cmd_ready), 64'd1);
        chk("rst.b.rsp_valid", 64'(b_rsp_valid), 64'd0);
        chk("rst.b.rdata",     b_rsp_rdata,      64'd0);
        @(posedge clk);
        #1;

        // Instance A: back-to-back, partial writes, zero mask, out of range, top word.
        a_cycle("a01", 1, 0, 12'h010, 32'hA5A5_1234, 4'hF, 0, 32'h0, 0);
        a_cycle("a02", 1, 1, 12'h010, 32'h0,         4'h0, 1, 32'h0, 0);
        a_cycle("a03", 1, 0, 12'h020, 32'hFFFF_FFFF, 4'hF, 1, 32'hA5A5_1234, 0);
        a_cycle("a04", 1, 0, 12'h020, 32'h0,         4'h5, 1, 32'h0, 0);
        a_cycle("a05", 1, 1, 12'h020, 32'h0,         4'h0, 1, 32'h0, 0);
        a_cycle("a06", 1, 0, 12'h020, 32'hDEAD_BEEF, 4'h0, 1, 32'hFF00_FF00, 0);
        a_cycle("a07", 1, 1, 12'h020, 32'h0,         4'h0, 1, 32'h0, 0);
        a_cycle("a08", 1, 1, 12'hC04, 32'h0,         4'h0, 1, 32'hFF00_FF00, 0);
        a_cycle("a09", 1, 1, 12'h010, 32'h0,         4'h0, 1, 32'h0, 1);
        a_cycle("a10", 1, 0, 12'hBFC, 32'h1357_9BDF, 4'hF, 1, 32'hA5A5_1234, 0);
        a_cycle("a11", 1, 1, 12'hBFC, 32'h0,         4'h0, 1, 32'h0, 0);
        a_cycle("a12", 0, 0, 12'h000, 32'h0,         4'h0, 1, 32'h1357_9BDF, 0);
        a_cycle("a13", 0, 0, 12'h000, 32'h0,         4'h0, 0, 32'h0, 0);

        // Instance B: 64-bit byte-masked write, latency 2.
        b_cycle("b01", 1, 0, 12'h100, 64'h0, 8'hFF, 1, 1, 0, 64'h0);
        b_cycle("b02", 1, 0, 12'h100, 64'h1122_3344_5566_7788, 8'hF0, 1, 1, 0, 64'h0);
        b_cycle("b03", 0, 0, 12'h000, 64'h0, 8'h00, 1, 0, 1, 64'h0);
        b_cycle("b04", 1, 1, 12'h100, 64'h0, 8'h00, 1, 1, 1, 64'h0);
        b_cycle("b05", 0, 0, 12'h000, 64'h0, 8'h00, 1, 1, 0, 64'h0);
        b_cycle("b06", 0, 0, 12'h000, 64'h0, 8'h00, 1, 1, 1, 64'h1122_3344_0000_0000);
        b_cycle("b07", 0, 0, 12'h000, 64'h0, 8'h00, 1, 1, 0, 64'h0);

        b_cycle("b08", 1, 0, 12'h200, DA, 8'hFF, 1, 1, 0, 64'h0);
        b_cycle("b09", 1, 0, 12'h208, DB, 8'hFF, 1, 1, 0, 64'h0);
        b_cycle("b10", 0, 0, 12'h000, 64'h0, 8'h00, 1, 0, 1, 64'h0);
        b_cycle("b11", 0, 0, 12'h000, 64'h0, 8'h00, 1, 1, 1, 64'h0);
        b_cycle("b12", 0, 0, 12'h000, 64'h0, 8'h00, 1, 1, 0, 64'h0);

        // Back-pressure: four reads offered, only two accepted, drained in order.
        b_cycle("bp1", 1, 1, 12'h200, 64'h0, 8'h00, 0, 1, 0, 64'h0);
        b_cycle("bp2", 1, 1, 12'h208, 64'h0, 8'h00, 0, 1, 0, 64'h0);
        b_cycle("bp3", 1, 1, 12'h210, 64'h0, 8'h00, 0, 0, 1, DA);
        b_cycle("bp4", 1, 1, 12'h218, 64'h0, 8'h00, 0, 0, 1, DA);
        b_cycle("bp5", 0, 0, 12'h000, 64'h0, 8'h00, 0, 0, 1, DA);
        b_cycle("bp6", 0, 0, 12'h000, 64'h0, 8'h00, 1, 0, 1, DA);
        b_cycle("bp7", 0, 0, 12'h000, 64'h0, 8'h00, 1, 1, 1, DB);
        b_cycle("bp8", 0, 0, 12'h000, 64'h0, 8'h00, 1, 1, 0, 64'h0);
        b_cycle("bp9", 0, 0, 12'h000, 64'h0, 8'h00, 1, 1, 0, 64'h0);

        // Reset with two responses pending discards them; RAM contents survive.
        b_cycle("mr1", 1, 1, 12'h200, 64'h0, 8'h00, 0, 1, 0, 64'h0);
        b_cycle("mr2", 1, 1, 12'h208, 64'h0, 8'h00, 0, 1, 0, 64'h0);
        b_cycle("mr3", 0, 0, 12'h000, 64'h0, 8'h00, 0, 0, 1, DA);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr.rsp_valid", 64'(b_rsp_valid), 64'd0);
        chk("mr.cmd_ready", 64'(b_cmd_ready), 64'd1);
        chk("mr.rdata",     b_rsp_rdata,      64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        b_cycle("mr4", 1, 1, 12'h208, 64'h0, 8'h00, 1, 1, 0, 64'h0);
        b_cycle("mr5", 0, 0, 12'h000, 64'h0, 8'h00, 1, 1, 0, 64'h0);
        b_cycle("mr6", 0, 0, 12'h000, 64'h0, 8'h00, 1, 1, 1, DB);
        b_cycle("mr7", 0, 0, 12'h000, 64'h0, 8'h00, 1, 1, 0, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
